// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared constants, types and the address-legality rule for the register file
// bank and its scoreboard.
//   XLEN_D / NREGS_D : default data width and register count
//   reg_addr_t       : architectural register address (5 bits)
//   reg_data_t       : architectural register value (32 bits)
//   addr_legal()     : 1 when an address names a real, writable register
// -----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int XLEN_D  = 32;
  localparam int NREGS_D = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

  // One rule covers reads, writes and claims: the address must exist, and
  // with a hardwired zero register, address 0 behaves as if it did not.
  function automatic logic addr_legal(input int unsigned addr,
                                      input int unsigned nregs,
                                      input logic        zero_reg);
    return (addr < nregs) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Pending-write tracker used by decode to detect RAW hazards.
//   clk, rst_n  : clock, synchronous active-low clear of all pending bits
//   rd_addr     : NRD packed read addresses to look up
//   wr_en/addr  : register write; a legal write clears its pending bit
//   claim_en/addr : issuing instruction marks a register pending
//   rd_pend     : per-port pending bit of the addressed register
//   pend_cnt    : number of pending registers (registered)
// -----------------------------------------------------------------------------
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int  NREGS    = NREGS_D,
  parameter int  NRD      = 2,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS),
  localparam int CW       = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic              claim_en,
  input  logic [AW-1:0]     claim_addr,
  output logic [NRD-1:0]    rd_pend,
  output logic [CW-1:0]     pend_cnt
);

  logic [NREGS-1:0] r_pend;
  logic [CW-1:0]    r_cnt;
  logic             w_set;
  logic             w_clr;
  logic             w_inc;
  logic             w_dec;

  assign w_set = claim_en && addr_legal(32'(claim_addr), NREGS, ZERO_REG != 0);
  assign w_clr = wr_en && addr_legal(32'(wr_addr), NREGS, ZERO_REG != 0);

  // The counter tracks only real transitions of a bit. A write that lands on
  // a register being re-claimed in the same cycle is not a clear.
  assign w_inc = w_set && !r_pend[claim_addr];
  assign w_dec = w_clr && r_pend[wr_addr] && !(w_set && (claim_addr == wr_addr));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      // NOTE: non-blocking updates to the same bit resolve to the last one
      // scheduled, so ordering the claim after the clear gives it priority.
      if (w_clr) r_pend[wr_addr]    <= 1'b0;
      if (w_set) r_pend[claim_addr] <= 1'b1;
      r_cnt <= r_cnt + CW'(w_inc) - CW'(w_dec);
    end
  end

  assign pend_cnt = r_cnt;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_busy
    logic [AW-1:0] w_addr;
    assign w_addr      = rd_addr[gi*AW +: AW];
    assign rd_pend[gi] = addr_legal(32'(w_addr), NREGS, ZERO_REG != 0) && r_pend[w_addr];
  end

endmodule

// File: rtl/reg_file_bank.sv
// -----------------------------------------------------------------------------
// reg_file_bank
// Multi-read-port general-purpose register file with write bypass, a
// synchronous clear, a pending-write scoreboard and a debug read port.
//   clk, rst_n    : clock, synchronous active-low clear of array and scoreboard
//   rd_addr       : NRD packed read addresses (port i at [i*AW +: AW])
//   rd_data       : NRD packed combinational read data (port i at [i*XLEN +: XLEN])
//   rd_busy       : per-port "register has an outstanding write"
//   wr_en/addr/data : single write port
//   claim_en/addr : reserve a register as pending for a new producer
//   pend_cnt      : number of pending registers
//   dbg_addr/data : debug read, never bypassed
// -----------------------------------------------------------------------------
module reg_file_bank
  import reg_file_pkg::*;
#(
  parameter int  XLEN     = XLEN_D,
  parameter int  NREGS    = NREGS_D,
  parameter int  AW       = $clog2(NREGS),
  parameter int  NRD      = 2,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int CW       = $clog2(NREGS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  output logic [CW-1:0]       pend_cnt,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_wr_ok;
  logic [NRD-1:0]  w_pend;

  assign w_wr_ok = wr_en && addr_legal(32'(wr_addr), NREGS, ZERO_REG != 0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the array is architecturally cleared by reset, so it is built
      // from resettable flops rather than left to a RAM macro.
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  reg_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .rd_pend    (w_pend),
    .pend_cnt   (pend_cnt)
  );

  // A bypassed port sees the value being written, so the register is no
  // longer outstanding from that reader's point of view.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_legal;
    logic          w_hit;
    assign w_addr  = rd_addr[gi*AW +: AW];
    assign w_legal = addr_legal(32'(w_addr), NREGS, ZERO_REG != 0);
    assign w_hit   = (BYPASS != 0) && w_wr_ok && (wr_addr == w_addr);
    assign rd_data[gi*XLEN +: XLEN] = !rst_n  ? '0 :
                                      w_hit   ? wr_data :
                                      w_legal ? r_mem[w_addr] : '0;
    assign rd_busy[gi] = rst_n && !w_hit && w_pend[gi];
  end

  logic w_dbg_legal;
  assign w_dbg_legal = addr_legal(32'(dbg_addr), NREGS, ZERO_REG != 0);
  assign dbg_data    = (rst_n && w_dbg_legal) ? r_mem[dbg_addr] : '0;

endmodule

// File: doc/reg_file_bank.md
# reg_file_bank

Parametrised multi-read-port general-purpose register file for the CPU datapath, the next generation of the single-write, two-read register file. It adds a configurable read-port count, same-cycle write-to-read bypass, a synchronous active-low clear of the whole array, and a pending-write scoreboard that lets the pipelined decode stage detect RAW hazards. A debug read port replaces simulation-only register dumps.

## Interface
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers (2..64)
- AW, $clog2(NREGS), register address width
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never pending
- BYPASS, 1, 1 = read ports see the write data of the current cycle
- One clock; reset is synchronous and active-low.
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- rd_addr  in  NRD*AW  read addresses, port i in bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port i in bits [i*XLEN +: XLEN]
- rd_busy  out  NRD  port i's register has an outstanding write
- wr_en  in  1  write enable
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- claim_en  in  1  issuing instruction reserves claim_addr as pending
- claim_addr  in  AW  register to mark pending
- pend_cnt  out  $clog2(NREGS+1)  number of pending registers
- dbg_addr  in  AW  debug read address
- dbg_data  out  XLEN  debug read data (never bypassed)

## Operation
- Storage: NREGS x XLEN array plus NREGS pending bits.
- Write: wr_en=1 with valid address stores wr_data at rising edge. With ZERO_REG=1, writes to address 0 are dropped.
- Read: combinational. rd_data[i] = array[rd_addr[i]]. Address 0 with ZERO_REG=1 reads 0.
- Bypass (BYPASS=1): if wr_en and wr_addr==rd_addr[i] and the write is not dropped, rd_data[i]=wr_data in the same cycle. dbg_data never bypasses.
- Out-of-range address (>= NREGS): reads return 0, busy reads 0, writes and claims are ignored.
- Scoreboard:
  - claim_en sets pending[claim_addr].
  - A valid write clears pending[wr_addr].
  - Claim and write to the same register in one cycle: pending ends set, because the claim (new producer) wins.
  - Claim of an already-pending register leaves it set; pend_cnt is unchanged.
  - Claims to register 0 are ignored when ZERO_REG=1.
- rd_busy[i] = pending[rd_addr[i]]. With BYPASS=1, it is masked to 0 when the current-cycle write matches. A same-cycle claim does not raise busy until the next cycle.
- pend_cnt is a registered counter: +1 on a new set, -1 on a clear of a set bit, net 0 when both happen. It always equals the popcount of the pending bits.

## Timing
- Read latency 0 cycles (combinational). Write and claim visible to non-bypassed reads one cycle later.
- Reset: while rst_n=0 at a rising edge, every register is cleared to 0, every pending bit is cleared, and pend_cnt goes to 0. Writes and claims in that cycle are ignored.
- While rst_n=0, rd_data, rd_busy and dbg_data are forced to 0 combinationally, and bypass is suppressed.
- Reset asserted mid-operation discards all outstanding claims. The first legal write or claim is in the first cycle with rst_n=1.
- No internal state machine beyond the array and scoreboard. Reads never stall.

## Structure
- reg_file_pkg holds:
  - default constants XLEN_D=32 and NREGS_D=32
  - typedef reg_addr_t (logic [4:0])
  - typedef reg_data_t (logic [31:0])
- Sub-module reg_scoreboard contains the pending bits, the claim/clear priority, the per-port busy lookup and pend_cnt. It takes parameters NREGS, NRD and ZERO_REG.
- The array, bypass muxes and debug port live in reg_file_bank.

## Test plan
- Reset then read: pulse rst_n=0 for 1 cycle after writing r5=0xDEADBEEF -> rd_data of r5 is 0, pend_cnt=0, all rd_busy=0.
- Write then read: write r3=0x12345678 at cycle 1, read r3 on port 1 at cycle 2 -> 0x12345678. Write r0=0xFFFFFFFF -> r0 reads 0.
- Bypass: wr_en, r7=0xA5A5A5A5 with rd_addr[0]=7 in the same cycle -> rd_data[0]=0xA5A5A5A5 in that cycle, dbg_data at r7 shows the old value, rd_busy[0]=0 even if r7 was pending.
- Scoreboard: claim r9, then claim r10 -> pend_cnt=2, busy on r9. Write r9 -> pend_cnt=1. Claim and write r10 in the same cycle -> r10 stays pending, pend_cnt=1.
- Config sweep: NREGS=24, NRD=4, ZERO_REG=0 -> r0 is writable, address 30 reads 0 and the write to it is ignored, all 4 ports read independent registers.
- Mid-operation reset: claim r4 and r6, assert rst_n=0 together with wr_en to r4 -> after reset pend_cnt=0 and r4 reads 0.
